// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RV32I controller: state encodings,
// opcodes and datapath select codes. ILLEGAL_TRAP_EN adds the TRAP state.
package riscv_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
`ifdef ILLEGAL_TRAP_EN
      S_JALRPC   = 4'd12,
      S_TRAP     = 4'd13
`else
      S_JALRPC   = 4'd12
`endif
   } mc_state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   function automatic logic is_mem_op(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational map from IR opcode to the state that follows DECODE,
// flagging opcodes the controller does not implement.
module mc_opcode_decode
   import riscv_mc_pkg::*;
(
   input  logic [6:0] op_code_i,
   output mc_state_e  next_state_o,
   output logic       illegal_o
);

   // Opcode lookup; unknown opcodes fall back to FETCH with the flag raised
   always_comb begin
      next_state_o = S_FETCH;
      illegal_o    = 1'b0;
      if (is_mem_op(op_code_i)) begin
         next_state_o = S_MEMADR;
      end else begin
         case (op_code_i)
            OP_OP:     next_state_o = S_EXECR;
            OP_OPIMM:  next_state_o = S_EXECI;
            OP_BRANCH: next_state_o = S_BEQ;
            OP_JAL:    next_state_o = S_JAL;
            OP_JALR:   next_state_o = S_JALR;
            default: begin
               next_state_o = S_FETCH;
               illegal_o    = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle RV32I datapath with a memory-ready handshake.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes instead of skipping them.
module multicycle_controller
   import riscv_mc_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         opCode,
   input  logic               zero,
   input  logic               memReady,
   output logic               pcWrite,
   output logic               irWrite,
   output logic               adrSrc,
   output logic               memRead,
   output logic               memWrite,
   output logic               regWrite,
   output logic               branch,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         resultSrc,
   output logic [1:0]         ALUOp,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

`ifdef ILLEGAL_TRAP_EN
   localparam mc_state_e ILLEGAL_NEXT = S_TRAP;
`else
   localparam mc_state_e ILLEGAL_NEXT = S_FETCH;
`endif

   mc_state_e state_q;
   mc_state_e state_d;
   mc_state_e dec_next_s;
   logic      dec_illegal_s;

   mc_opcode_decode u_decode (
      .op_code_i    (opCode),
      .next_state_o (dec_next_s),
      .illegal_o    (dec_illegal_s)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; opCode only matters in DECODE and MEMADR
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (memReady) begin
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            if (dec_illegal_s) begin
               state_d = ILLEGAL_NEXT;
            end else begin
               state_d = dec_next_s;
            end
         end
         S_MEMADR: begin
            if (opCode == OP_STORE) begin
               state_d = S_MEMWRITE;
            end else begin
               state_d = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            if (memReady) begin
               state_d = S_MEMWB;
            end else begin
               state_d = S_MEMREAD;
            end
         end
         S_MEMWRITE: begin
            if (memReady) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_MEMWRITE;
            end
         end
         S_MEMWB:  state_d = S_FETCH;
         S_EXECR:  state_d = S_ALUWB;
         S_EXECI:  state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BEQ:    state_d = S_FETCH;
         S_JAL:    state_d = S_ALUWB;
         S_JALR:   state_d = S_JALRPC;
         S_JALRPC: state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
         S_TRAP:   state_d = S_TRAP;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   // Control decode from the current state; reset masks every enable and select
   always_comb begin
      pcWrite   = 1'b0;
      irWrite   = 1'b0;
      adrSrc    = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      regWrite  = 1'b0;
      branch    = 1'b0;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      resultSrc = RES_ALUOUT;
      ALUOp     = ALUOP_ADD;
      if (reset) begin
         pcWrite  = 1'b0;
         memWrite = 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               memRead   = 1'b1;
               adrSrc    = 1'b0;
               ALUSrcA   = SRCA_PC;
               ALUSrcB   = SRCB_FOUR;
               ALUOp     = ALUOP_ADD;
               resultSrc = RES_ALURESULT;
               pcWrite   = memReady;
               irWrite   = memReady;
            end
            S_DECODE: begin
               ALUSrcA = SRCA_OLDPC;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALUOP_ADD;
            end
            S_MEMREAD: begin
               adrSrc  = 1'b1;
               memRead = 1'b1;
            end
            S_MEMWB: begin
               resultSrc = RES_MEMDATA;
               regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
               adrSrc   = 1'b1;
               memWrite = 1'b1;
            end
            S_EXECR: begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_RS2;
               ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
               resultSrc = RES_ALUOUT;
               regWrite  = 1'b1;
            end
            S_BEQ: begin
               ALUSrcA   = SRCA_RS1;
               ALUSrcB   = SRCB_RS2;
               ALUOp     = ALUOP_SUB;
               resultSrc = RES_ALUOUT;
               branch    = 1'b1;
               pcWrite   = zero;
            end
            S_JAL, S_JALRPC: begin
               // PC <- target held in ALUOut while ALU forms the link oldPC+4
               ALUSrcA   = SRCA_OLDPC;
               ALUSrcB   = SRCB_FOUR;
               ALUOp     = ALUOP_ADD;
               resultSrc = RES_ALUOUT;
               pcWrite   = 1'b1;
            end
            S_JALR: begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALUOP_ADD;
            end
            default: begin
               pcWrite  = 1'b0;
               memWrite = 1'b0;
            end
         endcase
      end
   end

`ifdef ILLEGAL_TRAP_EN
   assign illegal = (state_q == S_TRAP);
`else
   assign illegal = 1'b0;
`endif

   assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class,
// memory waits, mid-access reset and the unknown-opcode path.
module tb_multicycle_controller;
   import riscv_mc_pkg::*;

   localparam int STATE_W = 4;

   // Control vector: {pcWrite,irWrite,adrSrc, memRead,memWrite,regWrite,branch, A,B,resultSrc,ALUOp}
   localparam logic [14:0] C_NONE       = 15'b000_0000_00_00_00_00;
   localparam logic [14:0] C_FETCH_RDY  = 15'b110_1000_00_10_10_00;
   localparam logic [14:0] C_FETCH_WAIT = 15'b000_1000_00_10_10_00;
   localparam logic [14:0] C_DECODE     = 15'b000_0000_01_01_00_00;
   localparam logic [14:0] C_ADDR       = 15'b000_0000_10_01_00_00;
   localparam logic [14:0] C_MEMREAD    = 15'b001_1000_00_00_00_00;
   localparam logic [14:0] C_MEMWB      = 15'b000_0010_00_00_01_00;
   localparam logic [14:0] C_MEMWRITE   = 15'b001_0100_00_00_00_00;
   localparam logic [14:0] C_EXECR      = 15'b000_0000_10_00_00_10;
   localparam logic [14:0] C_EXECI      = 15'b000_0000_10_01_00_10;
   localparam logic [14:0] C_ALUWB      = 15'b000_0010_00_00_00_00;
   localparam logic [14:0] C_BEQ_T      = 15'b100_0001_10_00_00_01;
   localparam logic [14:0] C_BEQ_NT     = 15'b000_0001_10_00_00_01;
   localparam logic [14:0] C_JUMP       = 15'b100_0000_01_10_00_00;

   logic               clk;
   logic               reset;
   logic [6:0]         opCode;
   logic               zero;
   logic               memReady;
   logic               pcWrite, irWrite, adrSrc, memRead, memWrite, regWrite, branch;
   logic [1:0]         ALUSrcA, ALUSrcB, resultSrc, ALUOp;
   logic               illegal;
   logic [STATE_W-1:0] state;
   logic [14:0]        obs_ctl;

   int vectors     = 0;
   int miscompares = 0;

   multicycle_controller #(.STATE_W(STATE_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .opCode    (opCode),
      .zero      (zero),
      .memReady  (memReady),
      .pcWrite   (pcWrite),
      .irWrite   (irWrite),
      .adrSrc    (adrSrc),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .regWrite  (regWrite),
      .branch    (branch),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .resultSrc (resultSrc),
      .ALUOp     (ALUOp),
      .illegal   (illegal),
      .state     (state)
   );

   assign obs_ctl = {pcWrite, irWrite, adrSrc, memRead, memWrite, regWrite, branch,
                     ALUSrcA, ALUSrcB, resultSrc, ALUOp};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Check one cycle mid-period, then advance past the next rising edge
   task automatic cyc(input string tag, input mc_state_e exp_st, input logic [14:0] exp_ctl,
                      input logic exp_ill, input bit chk_st, input bit chk_ill);
      #4;
      if (chk_st) begin
         vectors++;
         assert (state === STATE_W'(exp_st)) else begin
            miscompares++;
            $error("FAIL %s.state observed=%0d expected=%0d", tag, state, exp_st);
         end
      end
      vectors++;
      assert (obs_ctl === exp_ctl) else begin
         miscompares++;
         $error("FAIL %s.ctl observed=%b expected=%b", tag, obs_ctl, exp_ctl);
      end
      if (chk_ill) begin
         vectors++;
         assert (illegal === exp_ill) else begin
            miscompares++;
            $error("FAIL %s.illegal observed=%b expected=%b", tag, illegal, exp_ill);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b1;
      memReady = 1'b1;
      zero     = 1'b0;
      opCode   = OP_LOAD;

      cyc("rst0", S_FETCH, C_NONE, 1'b0, 1'b0, 1'b1);
      cyc("rst1", S_FETCH, C_NONE, 1'b0, 1'b1, 1'b1);
      reset = 1'b0;

      // lw, zero-wait: 5 cycles
      cyc("lw_fetch",   S_FETCH,   C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("lw_decode",  S_DECODE,  C_DECODE,    1'b0, 1'b1, 1'b1);
      cyc("lw_memadr",  S_MEMADR,  C_ADDR,      1'b0, 1'b1, 1'b1);
      cyc("lw_memread", S_MEMREAD, C_MEMREAD,   1'b0, 1'b1, 1'b1);
      cyc("lw_memwb",   S_MEMWB,   C_MEMWB,     1'b0, 1'b1, 1'b1);

      // lw with 3 wait cycles: 8 cycles
      cyc("lww_fetch",  S_FETCH,   C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("lww_decode", S_DECODE,  C_DECODE,    1'b0, 1'b1, 1'b1);
      cyc("lww_memadr", S_MEMADR,  C_ADDR,      1'b0, 1'b1, 1'b1);
      memReady = 1'b0;
      cyc("lww_wait1",  S_MEMREAD, C_MEMREAD,   1'b0, 1'b1, 1'b1);
      cyc("lww_wait2",  S_MEMREAD, C_MEMREAD,   1'b0, 1'b1, 1'b1);
      cyc("lww_wait3",  S_MEMREAD, C_MEMREAD,   1'b0, 1'b1, 1'b1);
      memReady = 1'b1;
      cyc("lww_rdy",    S_MEMREAD, C_MEMREAD,   1'b0, 1'b1, 1'b1);
      cyc("lww_memwb",  S_MEMWB,   C_MEMWB,     1'b0, 1'b1, 1'b1);

      // sw: 4 cycles
      opCode = OP_STORE;
      cyc("sw_fetch",   S_FETCH,    C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("sw_decode",  S_DECODE,   C_DECODE,    1'b0, 1'b1, 1'b1);
      cyc("sw_memadr",  S_MEMADR,   C_ADDR,      1'b0, 1'b1, 1'b1);
      cyc("sw_write",   S_MEMWRITE, C_MEMWRITE,  1'b0, 1'b1, 1'b1);

      // sw held by memory, then aborted by reset with no write
      cyc("swa_fetch",  S_FETCH,    C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("swa_decode", S_DECODE,   C_DECODE,    1'b0, 1'b1, 1'b1);
      cyc("swa_memadr", S_MEMADR,   C_ADDR,      1'b0, 1'b1, 1'b1);
      memReady = 1'b0;
      cyc("swa_hold",   S_MEMWRITE, C_MEMWRITE,  1'b0, 1'b1, 1'b1);
      reset = 1'b1;
      cyc("swa_abort",  S_MEMWRITE, C_NONE,      1'b0, 1'b1, 1'b1);
      reset = 1'b0;

      // FETCH stalls without touching PC/IR
      cyc("fetch_wait", S_FETCH, C_FETCH_WAIT, 1'b0, 1'b1, 1'b1);
      memReady = 1'b1;

      // R-type; opCode change in EXECR must not redirect
      opCode = OP_OP;
      cyc("r_fetch",  S_FETCH,  C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("r_decode", S_DECODE, C_DECODE,    1'b0, 1'b1, 1'b1);
      opCode = OP_STORE;
      cyc("r_exec",   S_EXECR,  C_EXECR,     1'b0, 1'b1, 1'b1);
      cyc("r_aluwb",  S_ALUWB,  C_ALUWB,     1'b0, 1'b1, 1'b1);

      // I-type
      opCode = OP_OPIMM;
      cyc("i_fetch",  S_FETCH,  C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("i_decode", S_DECODE, C_DECODE,    1'b0, 1'b1, 1'b1);
      cyc("i_exec",   S_EXECI,  C_EXECI,     1'b0, 1'b1, 1'b1);
      cyc("i_aluwb",  S_ALUWB,  C_ALUWB,     1'b0, 1'b1, 1'b1);

      // beq taken and not taken
      opCode = OP_BRANCH;
      zero   = 1'b1;
      cyc("beqt_fetch",  S_FETCH,  C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("beqt_decode", S_DECODE, C_DECODE,    1'b0, 1'b1, 1'b1);
      cyc("beqt_beq",    S_BEQ,    C_BEQ_T,     1'b0, 1'b1, 1'b1);
      zero = 1'b0;
      cyc("beqn_fetch",  S_FETCH,  C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("beqn_decode", S_DECODE, C_DECODE,    1'b0, 1'b1, 1'b1);
      cyc("beqn_beq",    S_BEQ,    C_BEQ_NT,    1'b0, 1'b1, 1'b1);

      // jal: 4 cycles
      opCode = OP_JAL;
      cyc("jal_fetch",  S_FETCH,  C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("jal_decode", S_DECODE, C_DECODE,    1'b0, 1'b1, 1'b1);
      cyc("jal_jal",    S_JAL,    C_JUMP,      1'b0, 1'b1, 1'b1);
      cyc("jal_aluwb",  S_ALUWB,  C_ALUWB,     1'b0, 1'b1, 1'b1);

      // jalr: 5 cycles
      opCode = OP_JALR;
      cyc("jalr_fetch",  S_FETCH,  C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("jalr_decode", S_DECODE, C_DECODE,    1'b0, 1'b1, 1'b1);
      cyc("jalr_jalr",   S_JALR,   C_ADDR,      1'b0, 1'b1, 1'b1);
      cyc("jalr_pc",     S_JALRPC, C_JUMP,      1'b0, 1'b1, 1'b1);
      cyc("jalr_aluwb",  S_ALUWB,  C_ALUWB,     1'b0, 1'b1, 1'b1);

      // Unknown opcode
      opCode = 7'b1111111;
      cyc("ill_fetch",  S_FETCH,  C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("ill_decode", S_DECODE, C_DECODE,    1'b0, 1'b1, 1'b1);
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) begin
         cyc("ill_trap", S_TRAP, C_NONE, 1'b1, 1'b1, 1'b1);
      end
      reset = 1'b1;
      cyc("ill_rst", S_TRAP, C_NONE, 1'b0, 1'b1, 1'b0);
      reset = 1'b0;
      opCode = OP_LOAD;
      cyc("ill_clear", S_FETCH, C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
`else
      opCode = OP_LOAD;
      cyc("ill_nop",   S_FETCH,  C_FETCH_RDY, 1'b0, 1'b1, 1'b1);
      cyc("ill_after", S_DECODE, C_DECODE,    1'b0, 1'b1, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
